// File: rtl/ts_arb4_128.sv
// Four-channel round-robin packet arbiter forwarding one 128-bit beat stream.
// Packets are checked for sync framing and bounded in length; aborts are counted.
module ts_arb4_128 #(
    parameter int U_DLY   = 1,
    parameter int TIMEOUT = 64,
    parameter int MIN_GAP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    output logic [3:0]   grant,
    input  logic [3:0]   in_sync,
    input  logic [3:0]   in_valid,
    input  logic [3:0]   in_eop,
    input  logic [511:0] in_data,
    output logic         ts_sync,
    output logic         ts_valid,
    output logic         ts_eop,
    output logic [127:0] ts_data,
    output logic [1:0]   ts_chan,
    output logic [15:0]  pkt_cnt,
    output logic [7:0]   err_cnt,
    output logic         err_pulse
);

    // state   | meaning
    // ST_IDLE | waiting for any req; arbitrates round-robin
    // ST_XFER | forwarding beats of the granted channel
    // ST_GAP  | MIN_GAP forced idle cycles after a packet ends
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    if (TIMEOUT < 13 || TIMEOUT > 255) begin : g_bad_timeout
        $error("ts_arb4_128: TIMEOUT must be within 13..255");
    end
    if (MIN_GAP < 0 || MIN_GAP > 15) begin : g_bad_min_gap
        $error("ts_arb4_128: MIN_GAP must be within 0..15");
    end
    if (U_DLY < 0) begin : g_bad_u_dly
        $error("ts_arb4_128: U_DLY must not be negative");
    end

    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [3:0] GAP_LOAD  = 4'((MIN_GAP > 0) ? (MIN_GAP - 1) : 0);
    localparam state_t     END_STATE = (MIN_GAP > 0) ? ST_GAP : ST_IDLE;

    state_t         state_q, state_d;
    logic [3:0]     grant_q, grant_d;
    logic [1:0]     last_q, last_d;
    logic [1:0]     chan_q, chan_d;
    logic [7:0]     cyc_q, cyc_d;
    logic           first_q, first_d;
    logic [3:0]     gap_q, gap_d;
    logic           ts_sync_q, ts_sync_d;
    logic           ts_valid_q, ts_valid_d;
    logic           ts_eop_q, ts_eop_d;
    logic [127:0]   ts_data_q, ts_data_d;
    logic [1:0]     ts_chan_q, ts_chan_d;
    logic [15:0]    pkt_cnt_q, pkt_cnt_d;
    logic [7:0]     err_cnt_q, err_cnt_d;
    logic           err_pulse_q, err_pulse_d;

    logic           rr_hit;
    logic [1:0]     rr_idx;
    logic [1:0]     rr_cand;
    logic           sel_valid;
    logic           sel_sync;
    logic           sel_eop;
    logic [127:0]   sel_data;
    logic           done;
    logic           abort;

    // Search starts one past the last served channel; i == 4 wraps back to it.
    always_comb begin
        rr_hit  = 1'b0;
        rr_idx  = last_q;
        rr_cand = last_q;
        for (int i = 1; i <= 4; i++) begin
            rr_cand = last_q + 2'(i);
            if (!rr_hit && req[rr_cand]) begin
                rr_hit = 1'b1;
                rr_idx = rr_cand;
            end
        end
    end

    always_comb begin
        sel_valid = in_valid[chan_q];
        sel_sync  = in_sync[chan_q];
        sel_eop   = in_eop[chan_q];
        sel_data  = in_data[{chan_q, 7'd0} +: 128];
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        chan_d      = chan_q;
        cyc_d       = cyc_q;
        first_d     = first_q;
        gap_d       = gap_q;
        ts_sync_d   = 1'b0;
        ts_valid_d  = 1'b0;
        ts_eop_d    = 1'b0;
        ts_data_d   = '0;
        ts_chan_d   = ts_chan_q;
        pkt_cnt_d   = pkt_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        done        = 1'b0;
        abort       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rr_hit) begin
                    grant_d = 4'b0001 << rr_idx;
                    last_d  = rr_idx;
                    chan_d  = rr_idx;
                    cyc_d   = '0;
                    first_d = 1'b1;
                    state_d = ST_XFER;
                end
            end

            ST_XFER: begin
                cyc_d = cyc_q + 8'd1;
                if (sel_valid) begin
                    if (first_q && !sel_sync) begin
                        abort = 1'b1;
                    end else begin
                        ts_valid_d = 1'b1;
                        ts_sync_d  = sel_sync;
                        ts_eop_d   = sel_eop;
                        ts_data_d  = sel_data;
                        ts_chan_d  = chan_q;
                        first_d    = 1'b0;
                        // A repeated sync is still forwarded, then the packet is dropped.
                        if (sel_sync && !first_q) begin
                            abort = 1'b1;
                        end else if (sel_eop) begin
                            done = 1'b1;
                        end
                    end
                end
                if (!done && !abort && cyc_q == TO_LAST) begin
                    abort = 1'b1;
                end
                if (done || abort) begin
                    grant_d = '0;
                    gap_d   = GAP_LOAD;
                    state_d = END_STATE;
                end
                if (done) begin
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                end
                if (abort) begin
                    err_pulse_d = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end

            ST_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            last_q      <= 2'd3;
            chan_q      <= 2'd0;
            cyc_q       <= '0;
            first_q     <= 1'b0;
            gap_q       <= '0;
            ts_sync_q   <= 1'b0;
            ts_valid_q  <= 1'b0;
            ts_eop_q    <= 1'b0;
            ts_data_q   <= '0;
            ts_chan_q   <= 2'd0;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            chan_q      <= chan_d;
            cyc_q       <= cyc_d;
            first_q     <= first_d;
            gap_q       <= gap_d;
            ts_sync_q   <= ts_sync_d;
            ts_valid_q  <= ts_valid_d;
            ts_eop_q    <= ts_eop_d;
            ts_data_q   <= ts_data_d;
            ts_chan_q   <= ts_chan_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign grant     = grant_q;
    assign ts_sync   = ts_sync_q;
    assign ts_valid  = ts_valid_q;
    assign ts_eop    = ts_eop_q;
    assign ts_data   = ts_data_q;
    assign ts_chan   = ts_chan_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign err_pulse = err_pulse_q;

endmodule
